// File: rtl/odev_pkg.sv
// Shared types and constants for the truth-table sweeper and its settle timer.
package odev_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } sweep_state_t;

  localparam int DEF_WIDTH = 5;
  localparam int TT_DEPTH  = 1 << DEF_WIDTH;
  localparam int CNT_W     = 8;

endpackage

// File: rtl/odev_settle_timer.sv
// Settle-time counter: counts enabled cycles from zero and flags the last one.
module odev_settle_timer
  import odev_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/odev1_truth_sweeper.sv
// Walks every input vector of the lab function block, waits for it to settle,
// and captures F into a truth table while counting the ones.
module odev1_truth_sweeper
  import odev_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic [WIDTH-1:0]        vec_out,
  input  logic                    f_in,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<WIDTH)-1:0]   truth_table,
  output logic [WIDTH:0]          ones_count
);

  localparam logic [WIDTH-1:0] LAST_VEC = '1;

  sweep_state_t state;
  logic         timer_clear;
  logic         timer_en;
  logic         expire;

  // The timer only runs in SETTLE, so it re-enters every vector from zero.
  assign timer_en    = (state == SETTLE);
  assign timer_clear = (state != SETTLE);

  odev_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (expire)
  );

  // busy/done are set alongside each state transition so they decode the
  // registered state without any path from start/abort/f_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vec_out     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
      ones_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state       <= SETTLE;
            vec_out     <= '0;
            truth_table <= '0;
            ones_count  <= '0;
            busy        <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state   <= IDLE;
            vec_out <= '0;
            busy    <= 1'b0;
          end else if (expire) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state   <= IDLE;
            vec_out <= '0;
            busy    <= 1'b0;
          end else begin
            truth_table[vec_out] <= f_in;
            ones_count           <= ones_count + {{WIDTH{1'b0}}, f_in};
            if (vec_out == LAST_VEC) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec_out <= vec_out + 1'b1;
              state   <= SETTLE;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_odev1_truth_sweeper.sv
// Scoreboard bench for the truth-table sweeper: two instances (settle 2 and 1)
// driven by a selectable lab function, checked against a whole-table model.
module tb_odev1_truth_sweeper;

  typedef struct {
    logic [31:0] tt;
    int          ones;
    int          accept;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, abort0, start1, abort1;
  logic [4:0]  vec0, vec1;
  logic        f0, f1;
  logic        busy0, done0, busy1, done1;
  logic [31:0] tt0, tt1;
  logic [5:0]  ones0, ones1;

  int          mode;
  logic [31:0] rnd_tt;
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  int          brun0 = 0;
  int          brun1 = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The lab function block under test: 0 = A..E LSB, 1 = one-hot at 10110,
  // 2 = constant one, otherwise an arbitrary random table.
  function automatic logic fmodel(input int m, input logic [4:0] v, input logic [31:0] r);
    case (m)
      0:       return v[0];
      1:       return (v == 5'b10110);
      2:       return 1'b1;
      default: return r[v];
    endcase
  endfunction

  assign f0 = fmodel(mode, vec0, rnd_tt);
  assign f1 = fmodel(mode, vec1, rnd_tt);

  odev1_truth_sweeper #(.WIDTH(5), .SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .vec_out(vec0),
    .f_in(f0), .busy(busy0), .done(done0), .truth_table(tt0), .ones_count(ones0)
  );

  odev1_truth_sweeper #(.WIDTH(5), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .vec_out(vec1),
    .f_in(f1), .busy(busy1), .done(done1), .truth_table(tt1), .ones_count(ones1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Expected sweep result: every vector i contributes F(i) to bit i.
  task automatic push(input int inst, input int acc);
    exp_t e;
    e.tt   = '0;
    e.ones = 0;
    for (int i = 0; i < 32; i++) begin
      logic b;
      b       = fmodel(mode, 5'(i), rnd_tt);
      e.tt[i] = b;
      e.ones += int'(b);
    end
    e.accept = acc;
    e.lat    = 32 * (((inst == 1) ? 1 : 2) + 1);
    if (inst == 1) q1.push_back(e);
    else           q0.push_back(e);
  endtask

  task automatic wait_drain(input int inst);
    int n;
    n = (inst == 1) ? q1.size() : q0.size();
    for (int k = 0; k < 300 && n != 0; k++) begin
      @(negedge clk);
      n = (inst == 1) ? q1.size() : q0.size();
    end
    chk("sweep_completed", 64'(n), 64'd0);
  endtask

  task automatic sweep(input int inst, input int m);
    mode = m;
    @(negedge clk);
    if (inst == 1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    push(inst, cyc);
    wait_drain(inst);
  endtask

  task automatic wait_vec(input logic [4:0] v);
    int k;
    k = 0;
    while (!(busy0 && vec0 == v) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_vector", 64'(busy0 && vec0 == v), 64'd1);
  endtask

  // Monitors: compare at every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        chk("spurious_done0", 64'd1, 64'd0);
      end else begin
        e0 = q0.pop_front();
        chk("tt0", 64'(tt0), 64'(e0.tt));
        chk("ones0", 64'(ones0), 64'(e0.ones));
        chk("vec_end0", 64'(vec0), 64'd31);
        chk("latency0", 64'(cyc - e0.accept), 64'(e0.lat));
        chk("busy_len0", 64'(brun0), 64'(e0.lat));
      end
      brun0 = 0;
    end else if (busy0) brun0++;
    else brun0 = 0;
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        chk("spurious_done1", 64'd1, 64'd0);
      end else begin
        e1 = q1.pop_front();
        chk("tt1", 64'(tt1), 64'(e1.tt));
        chk("ones1", 64'(ones1), 64'(e1.ones));
        chk("vec_end1", 64'(vec1), 64'd31);
        chk("latency1", 64'(cyc - e1.accept), 64'(e1.lat));
        chk("busy_len1", 64'(brun1), 64'(e1.lat));
      end
      brun1 = 0;
    end else if (busy1) brun1++;
    else brun1 = 0;
  end

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0; abort0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0;
    mode   = 0;
    rnd_tt = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vec", 64'(vec0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_tt", 64'(tt0), 64'd0);
    chk("rst_ones", 64'(ones0), 64'd0);

    // F = E, then hold check after the sweep.
    sweep(0, 0);
    repeat (3) @(negedge clk);
    chk("hold_vec", 64'(vec0), 64'd31);
    chk("hold_tt", 64'(tt0), 64'hAAAA_AAAA);
    chk("hold_ones", 64'(ones0), 64'd16);

    sweep(0, 1);
    for (int r = 0; r < 3; r++) begin
      rnd_tt = $urandom;
      sweep(0, 3);
    end

    // Settle of one cycle, all-ones F: ones_count must reach 32.
    sweep(1, 2);
    rnd_tt = $urandom;
    sweep(1, 3);

    // Abort in SETTLE while vector 3 is presented.
    mode = 2;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    wait_vec(5'd3);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_vec", 64'(vec0), 64'd0);
    chk("abort_tt", 64'(tt0), 64'h0000_0007);
    chk("abort_ones", 64'(ones0), 64'd3);
    repeat (110) @(negedge clk);

    // start and abort together in IDLE: no sweep, partial results kept.
    start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk);
    chk("startabort_busy", 64'(busy0), 64'd0);
    start0 = 1'b0; abort0 = 1'b0;
    @(negedge clk);
    chk("startabort_busy2", 64'(busy0), 64'd0);
    chk("startabort_tt", 64'(tt0), 64'h0000_0007);

    // start pulsed mid-sweep must not restart it (latency check catches it).
    rnd_tt = $urandom;
    mode   = 3;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    push(0, cyc);
    repeat (20) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_drain(0);

    // start held: second sweep follows FINISH+IDLE and clears the table.
    mode = 2;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk);
    push(0, cyc);
    for (int k = 0; k < 200 && !done0; k++) @(negedge clk);
    chk("held_first_done", 64'(done0), 64'd1);
    mode = 1;
    @(negedge clk);
    @(negedge clk);
    push(0, cyc);
    start0 = 1'b0;
    chk("held_rearm_busy", 64'(busy0), 64'd1);
    chk("held_rearm_clear", 64'(tt0), 64'd0);
    wait_drain(0);

    // Asynchronous reset in the middle of a sweep.
    mode = 2;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    wait_vec(5'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vec", 64'(vec0), 64'd0);
    chk("arst_busy", 64'(busy0), 64'd0);
    chk("arst_done", 64'(done0), 64'd0);
    chk("arst_tt", 64'(tt0), 64'd0);
    chk("arst_ones", 64'(ones0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    chk("arst_idle_busy", 64'(busy0), 64'd0);
    chk("arst_idle_tt", 64'(tt0), 64'd0);

    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odev1_truth_sweeper.md
Name: odev1_truth_sweeper

Overview:
- Sequential test-driver stage that sits directly upstream of the five-input lab function block (inputs A..E, output F).
- On command, it drives all 2^WIDTH input combinations in ascending order and waits a programmable settle time for each one.
- It samples the function output F back into a truth-table register and counts the 1s.
- Used on the board to dump the function's truth table to LEDs/UART without manual switch toggling.

Parameters:
- WIDTH, 5, number of function inputs; vec_out[WIDTH-1] drives A, vec_out[0] drives E.
- SETTLE_CYCLES, 2, cycles the vector is held before F is sampled; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled only in IDLE; begins a sweep.
- abort  input  1  level; terminates a sweep in progress.
- vec_out  output  WIDTH  input vector to the function block, MSB = A.
- f_in  input  1  function output F, combinational from vec_out.
- busy  output  1  high while sweeping (SETTLE or SAMPLE).
- done  output  1  one-cycle pulse when a full sweep completes.
- truth_table  output  2^WIDTH  bit i = F sampled with vec_out == i.
- ones_count  output  WIDTH+1  number of 1s captured in truth_table.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state IDLE; vec_out=0, busy=0, done=0, truth_table=0, ones_count=0, settle counter=0. Reset mid-sweep aborts immediately; no done pulse is produced.
- FSM states are IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - start=1 and abort=0 → SETTLE. On the same edge: vec_out←0, cnt←0, truth_table←0, ones_count←0.
  - start and abort both high → stay in IDLE (abort wins).
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE:
  - truth_table[vec_out]←f_in; ones_count←ones_count+f_in.
  - If vec_out==2^WIDTH-1 → FINISH.
  - Else vec_out←vec_out+1, cnt←0 → SETTLE.
  - vec_out never wraps inside a sweep.
- FINISH:
  - done=1 for exactly this one cycle.
  - Next state is IDLE.
  - vec_out holds 2^WIDTH-1 until the next start.
- Outputs:
  - busy = (state==SETTLE || state==SAMPLE). done = (state==FINISH). Both are registered state decodes, with no combinational path from inputs.
  - truth_table and ones_count hold their values in IDLE and FINISH until the next accepted start.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - The start-accept edge is edge 0. FINISH is entered at edge 2^WIDTH*(SETTLE_CYCLES+1), so done is high in the following cycle. With defaults: edge 96.
- abort:
  - In SETTLE or SAMPLE, abort → IDLE on the next edge. vec_out←0, no done pulse.
  - Partial truth_table/ones_count are retained. A SAMPLE write in the abort cycle is discarded.
  - abort in FINISH has no effect; done still pulses.
- start while busy is ignored. start held high through FINISH re-arms in IDLE on the following cycle, i.e. back-to-back sweeps are allowed.
- Width rule: ones_count is WIDTH+1 bits so that the all-ones case (2^WIDTH) fits without overflow.

Decomposition:
- Shared package odev_pkg contains:
  - state enum sweep_state_t {IDLE, SETTLE, SAMPLE, FINISH}.
  - localparam TT_DEPTH = 1<<WIDTH.
  - localparam CNT_W = 8.
- One natural sub-module: odev_settle_timer.
  - Inputs: clear, enable.
  - Output: expire.
  - Counts to SETTLE_CYCLES-1.
  - Uses the same clk/rst_n.

Test Plan:
1. Reset during sweep: start, then assert rst_n=0 at vector 7 → all outputs 0 asynchronously, state IDLE, no done pulse after release.
2. f_in tied to vec_out[0], defaults → done high in cycle 97 after start, truth_table=32'hAAAA_AAAA, ones_count=16, vec_out=31 afterward.
3. f_in = (vec_out==5'b10110) → truth_table=32'h0040_0000, ones_count=1; busy high for exactly 96 cycles.
4. f_in tied 1, SETTLE_CYCLES=1 → done at edge 64, truth_table=32'hFFFF_FFFF, ones_count=32 (no overflow).
5. Abort: f_in=1, abort asserted while vec_out==3 in SETTLE → IDLE next cycle, vec_out=0, no done, truth_table=32'h0000_0007, ones_count=3.
6. Corner handshakes:
   - start+abort together in IDLE → stays IDLE.
   - start pulsed while busy → ignored, no sweep restart.
   - start held high → second sweep begins the cycle after FINISH and clears truth_table.
